uart_pixel_fifo: RTL and testbench

UART_PIXEL_FIFO -- requirements
Module: uart_pixel_fifo

---
 rtl/uart_pixel_fifo_if.sv | 26 ++
 rtl/uart_pixel_fifo.sv | 111 +++++++++++
 tb/tb_uart_pixel_fifo.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pixel_fifo_if.sv
// uart_pixel_fifo_if: byte input, pixel stream output and UART flow-control signals.
// master is the pixel FIFO itself, slave is the surrounding UART/LCD logic.
interface uart_pixel_fifo_if #(
    parameter int FIFO_DEPTH = 16
) ();
    logic                        rx_data_valid;
    logic [7:0]                  rx_data_out;
    logic                        block_timeout;
    logic                        pix_ready;
    logic                        pix_valid;
    logic [15:0]                 pix_data;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    logic                        overflow;
    logic                        frame_done;
    logic                        tx_trig;
    logic [7:0]                  tx_data;
    logic                        tx_bsy;
    modport master (
        input  rx_data_valid, rx_data_out, block_timeout, pix_ready, tx_bsy,
        output pix_valid, pix_data, fifo_level, overflow, frame_done, tx_trig, tx_data
    );
    modport slave (
        output rx_data_valid, rx_data_out, block_timeout, pix_ready, tx_bsy,
        input  pix_valid, pix_data, fifo_level, overflow, frame_done, tx_trig, tx_data
    );
endinterface

// File: rtl/uart_pixel_fifo.sv
// uart_pixel_fifo: packs UART byte pairs into RGB565 pixels through a show-ahead FIFO.
// Define UART_PIXEL_FIFO_FLOW_CTRL_EN to build the XON/XOFF flow-control FSM.
module uart_pixel_fifo #(
    parameter int FIFO_DEPTH   = 16,
    parameter int FRAME_PIXELS = 42400,
    parameter int XOFF_LEVEL   = 12,
    parameter int XON_LEVEL    = 4
) (
    input logic               clk_27mhz,
    input logic               resetn,
    uart_pixel_fifo_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FRAME_PIXELS);
    localparam logic [AW:0]   FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST = CW'(FRAME_PIXELS - 1);

    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level;
    logic          phase;
    logic [7:0]    low_byte;
    logic [CW-1:0] pix_cnt;
    logic          ovf;
    logic          push, pop, wr;

    // a timeout coinciding with a byte restarts assembly with that byte
    assign push = bus.rx_data_valid & phase & ~bus.block_timeout;
    assign pop  = bus.pix_valid & bus.pix_ready;
    assign wr   = push & ((level != FULL) | pop);

    assign bus.pix_valid  = level != '0;
    assign bus.pix_data   = mem[rd_ptr];
    assign bus.fifo_level = level;
    assign bus.overflow   = ovf;
    assign bus.frame_done = pop & (pix_cnt == LAST);

    always_ff @(posedge clk_27mhz or negedge resetn) begin
        if (!resetn) begin
            phase    <= 1'b0;
            low_byte <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            ovf      <= 1'b0;
            pix_cnt  <= '0;
        end else begin
            if (bus.rx_data_valid | bus.block_timeout) phase <= bus.rx_data_valid & ~push;
            if (bus.rx_data_valid & ~push) low_byte <= bus.rx_data_out;
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + (AW+1)'(wr) - (AW+1)'(pop);
            if (push & ~wr) ovf <= 1'b1;
            if (pop) pix_cnt <= (pix_cnt == LAST) ? '0 : pix_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_27mhz)
        if (wr) mem[wr_ptr] <= {bus.rx_data_out, low_byte};

`ifdef UART_PIXEL_FIFO_FLOW_CTRL_EN
    typedef enum logic [1:0] {FLOW_ON, SEND_XOFF, FLOW_OFF, SEND_XON} flow_t;
    localparam logic [AW:0] XOFF_LVL = (AW+1)'(XOFF_LEVEL);
    localparam logic [AW:0] XON_LVL  = (AW+1)'(XON_LEVEL);

    flow_t      state, state_nxt;
    logic       trig_q, trig_nxt;
    logic [7:0] data_q, data_nxt;

    always_ff @(posedge clk_27mhz or negedge resetn) begin
        if (!resetn) begin
            state  <= FLOW_ON;
            trig_q <= 1'b0;
            data_q <= '0;
        end else begin
            state  <= state_nxt;
            trig_q <= trig_nxt;
            data_q <= data_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        trig_nxt  = 1'b0;
        data_nxt  = data_q;
        case (state)
            FLOW_ON:   if (level >= XOFF_LVL) state_nxt = SEND_XOFF;
            SEND_XOFF: if (!bus.tx_bsy) begin
                state_nxt = FLOW_OFF;
                trig_nxt  = 1'b1;
                data_nxt  = 8'h13;
            end
            FLOW_OFF:  if (level <= XON_LVL) state_nxt = SEND_XON;
            default:   if (!bus.tx_bsy) begin
                state_nxt = FLOW_ON;
                trig_nxt  = 1'b1;
                data_nxt  = 8'h11;
            end
        endcase
    end

    assign bus.tx_trig = trig_q;
    assign bus.tx_data = data_q;
`else
    logic unused_tx_bsy;
    localparam int unused_levels = XOFF_LEVEL + XON_LEVEL;
    assign unused_tx_bsy = bus.tx_bsy;
    assign bus.tx_trig   = 1'b0;
    assign bus.tx_data   = 8'h00;
`endif
endmodule

// File: tb/tb_uart_pixel_fifo.sv
// tb_uart_pixel_fifo: randomized scoreboard bench; driver queues assembled pixels,
// a negedge monitor applies FIFO/frame/flow rules and compares every DUT output.
module tb_uart_pixel_fifo;
    localparam int DEPTH = 16;
    localparam int FRAME = 8;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    uart_pixel_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

    uart_pixel_fifo #(
        .FIFO_DEPTH(DEPTH), .FRAME_PIXELS(FRAME), .XOFF_LEVEL(12), .XON_LEVEL(4)
    ) dut (
        .clk_27mhz(clk),
        .resetn   (resetn),
        .bus      (bus.master)
    );

    int          n_chk = 0, n_fail = 0;
    logic [15:0] pend[$];
    logic [15:0] exp_q[$];
    bit          have_low, bsy_en;
    logic [7:0]  low_b;
    int          pop_cnt;
    bit          ovf_m, off_m, want_m, trig_m;
    logic [7:0]  data_m;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(bit v, logic [7:0] b, bit to, bit rdy);
        @(posedge clk);
        #1;
        bus.rx_data_valid = v;
        bus.rx_data_out   = b;
        bus.block_timeout = to;
        bus.pix_ready     = rdy;
        bus.tx_bsy        = bsy_en && ($urandom_range(0, 2) == 0);
        if (to) begin
            have_low = v;
            low_b    = b;
        end else if (v) begin
            if (have_low) begin
                pend.push_back({b, low_b});
                have_low = 0;
            end else begin
                low_b    = b;
                have_low = 1;
            end
        end
    endtask

    task automatic pix(logic [15:0] p, bit rdy);
        drive(1, p[7:0], 0, rdy);
        drive(1, p[15:8], 0, rdy);
    endtask

    task automatic do_reset(int dly);
        @(posedge clk);
        #(dly);
        resetn = 0;
        bus.rx_data_valid = 0;
        bus.block_timeout = 0;
        bus.pix_ready = 0;
        bus.tx_bsy = 0;
        have_low = 0;
        repeat (2) @(posedge clk);
        #1 resetn = 1;
    endtask

    always @(negedge clk) begin
        int sz;
        bit pop;
        if (!resetn) begin
            exp_q.delete();
            pend.delete();
            pop_cnt = 0;
            ovf_m = 0; off_m = 0; want_m = 0; trig_m = 0; data_m = 8'h00;
            chk("rst_level", bus.fifo_level, 0);
            chk("rst_pix_valid", bus.pix_valid, 0);
            chk("rst_overflow", bus.overflow, 0);
            chk("rst_frame_done", bus.frame_done, 0);
            chk("rst_tx_trig", bus.tx_trig, 0);
            chk("rst_tx_data", bus.tx_data, 0);
        end else begin
            sz = exp_q.size();
            chk("fifo_level", bus.fifo_level, sz);
            chk("pix_valid", bus.pix_valid, sz != 0);
            if (sz != 0) chk("pix_data", bus.pix_data, exp_q[0]);
            chk("overflow", bus.overflow, ovf_m);
            pop = (sz != 0) && bus.pix_ready;
            chk("frame_done", bus.frame_done, pop && (pop_cnt % FRAME == FRAME - 1));
`ifdef UART_PIXEL_FIFO_FLOW_CTRL_EN
            chk("tx_trig", bus.tx_trig, trig_m);
            chk("tx_data", bus.tx_data, data_m);
            trig_m = 0;
            if (want_m) begin
                if (!bus.tx_bsy) begin
                    trig_m = 1;
                    data_m = off_m ? 8'h11 : 8'h13;
                    off_m  = !off_m;
                    want_m = 0;
                end
            end else if ((!off_m && sz >= 12) || (off_m && sz <= 4)) begin
                want_m = 1;
            end
`else
            chk("tx_trig_off", bus.tx_trig, 0);
            chk("tx_data_off", bus.tx_data, 0);
`endif
            if (pop) begin
                void'(exp_q.pop_front());
                pop_cnt++;
            end
            if (pend.size() != 0) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(pend.pop_front());
                else begin
                    void'(pend.pop_front());
                    ovf_m = 1;
                end
            end
        end
    end

    initial begin
        int pct[6] = '{0, 30, 60, 90, 100, 50};
        bus.rx_data_valid = 0;
        bus.rx_data_out = 0;
        bus.block_timeout = 0;
        bus.pix_ready = 0;
        bus.tx_bsy = 0;
        bsy_en = 0;
        have_low = 0;
        repeat (3) @(posedge clk);
        #1 resetn = 1;
        // single pixel, one-cycle latency, pop
        pix(16'h1234, 0);
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("first_px_valid", bus.pix_valid, 1);
        chk("first_px_data", bus.pix_data, 16'h1234);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("first_px_drained", bus.fifo_level, 0);
        // half pixel discarded by timeout
        drive(1, 8'hAA, 0, 0);
        drive(0, 0, 1, 0);
        pix(16'h1234, 0);
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("timeout_level", bus.fifo_level, 1);
        chk("timeout_data", bus.pix_data, 16'h1234);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);
        // overflow on 17th pixel
        for (int i = 0; i < 17; i++) pix({8'h50, 8'(i)}, 0);
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("full_level", bus.fifo_level, 16);
        chk("full_overflow", bus.overflow, 1);
        chk("full_head", bus.pix_data, 16'h5000);
        do_reset(1);
        // push and pop together while full
        for (int i = 0; i < 16; i++) pix({8'h50, 8'(i)}, 0);
        drive(1, 8'h10, 0, 0);
        drive(1, 8'h50, 0, 1);
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("pushpop_level", bus.fifo_level, 16);
        chk("pushpop_overflow", bus.overflow, 0);
        chk("pushpop_head", bus.pix_data, 16'h5001);
        repeat (20) drive(0, 0, 0, 1);
        // randomized traffic with varying back-pressure
        bsy_en = 1;
        for (int s = 0; s < 6; s++) begin
            repeat (400)
                drive($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 4,
                      $urandom_range(0, 99) < pct[s]);
            if (s == 3) do_reset(3);
        end
        bsy_en = 0;
        repeat (40) drive(0, 0, 0, 1);
        @(negedge clk);
        chk("final_drained", bus.fifo_level, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
